// File: rtl/core_clk_freq_pkg.sv
// Shared types and constants for the gated clock-frequency meter.
package core_clk_freq_pkg;

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    IDLE    = 2'd1,
    MEASURE = 2'd2
  } state_e;

  localparam int unsigned DEF_GATE_CYCLES = 50_000_000;
  localparam int unsigned OUT_W           = 32;

endpackage

// File: rtl/core_clk_freq_sync_edge.sv
// Synchroniser chain for the asynchronous measured signal plus rising-edge detect.
module core_clk_freq_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic meas_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], meas_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/core_clk_freq_meter.sv
// Gated frequency counter: counts synchronised rises of meas_in over GATE_CYCLES clocks
// and publishes the count on freq_out, held stable until the next publish.
module core_clk_freq_meter
  import core_clk_freq_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             oneshot,
  input  logic             start,
  input  logic             meas_in,
  output logic [OUT_W-1:0] freq_out,
  output logic             update,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
  localparam int unsigned WARM_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic [WARM_W-1:0]  warm_q, warm_d;
  logic [GATE_W-1:0]  gate_q, gate_d;
  logic [CNT_W-1:0]   edge_q, edge_d;
  logic               sat_q, sat_d;
  logic [OUT_W-1:0]   freq_q;
  logic               update_q, valid_q, ovf_q;

  logic               rise;
  logic               at_max;
  logic               terminal;
  logic               publish;
  logic [CNT_W-1:0]   result;
  logic               result_sat;

  core_clk_freq_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .reset_n(reset_n),
    .meas_in(meas_in),
    .rise   (rise)
  );

  assign at_max   = (edge_q == CNT_MAX);
  assign terminal = (gate_q == GATE_W'(GATE_CYCLES - 1));

  // A rise seen in the terminal cycle still belongs to the window that is ending.
  assign result     = (rise && !at_max) ? edge_q + 1'b1 : edge_q;
  assign result_sat = sat_q | (rise & at_max);

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    gate_d  = gate_q;
    edge_d  = edge_q;
    sat_d   = sat_q;
    publish = 1'b0;
    unique case (state_q)
      WARMUP: begin
        warm_d = warm_q + 1'b1;
        if (warm_q == WARM_W'(SYNC_STAGES)) state_d = IDLE;
      end
      IDLE: begin
        if (enable && (!oneshot || start)) begin
          state_d = MEASURE;
          gate_d  = '0;
          edge_d  = '0;
          sat_d   = 1'b0;
        end
      end
      MEASURE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (terminal) begin
          publish = 1'b1;
          gate_d  = '0;
          edge_d  = '0;
          sat_d   = 1'b0;
          if (oneshot) state_d = IDLE;
        end else begin
          gate_d = gate_q + 1'b1;
          if (rise) begin
            if (at_max) sat_d = 1'b1;
            else        edge_d = edge_q + 1'b1;
          end
        end
      end
      default: state_d = WARMUP;
    endcase
  end

  // update pulses in the first cycle the new freq_out/overflow are visible;
  // valid stays high from the first publish until reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= WARMUP;
      warm_q   <= '0;
      gate_q   <= '0;
      edge_q   <= '0;
      sat_q    <= 1'b0;
      freq_q   <= '0;
      update_q <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      gate_q   <= gate_d;
      edge_q   <= edge_d;
      sat_q    <= sat_d;
      update_q <= publish;
      if (publish) begin
        freq_q  <= OUT_W'(result);
        ovf_q   <= result_sat;
        valid_q <= 1'b1;
      end
    end
  end

  assign freq_out = freq_q;
  assign update   = update_q;
  assign valid    = valid_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == MEASURE);

endmodule

// File: tb/tb_core_clk_freq_meter.sv
// Bench for core_clk_freq_meter: two instances (32-bit and 4-bit counters) share stimulus;
// expected counts come from the recorded meas_in history.
module tb_core_clk_freq_meter;

  localparam int     G    = 100;
  localparam int     S    = 2;
  localparam int     MAXC = 32768;
  localparam longint MAX0 = 64'h0000_0000_FFFF_FFFF;
  localparam longint MAX1 = 15;
  localparam int     W    = 66;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        oneshot = 1'b0;
  logic        start = 1'b0;
  logic        meas_in = 1'b0;
  logic [31:0] freq0, freq1;
  logic        upd0, upd1, val0, val1, ovf0, ovf1, busy0, busy1;

  always #5 clk = ~clk;

  core_clk_freq_meter #(.GATE_CYCLES(G), .CNT_W(32), .SYNC_STAGES(S)) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .oneshot(oneshot), .start(start),
    .meas_in(meas_in), .freq_out(freq0), .update(upd0), .valid(val0),
    .overflow(ovf0), .busy(busy0)
  );

  core_clk_freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(S)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .oneshot(oneshot), .start(start),
    .meas_in(meas_in), .freq_out(freq1), .update(upd1), .valid(val1),
    .overflow(ovf1), .busy(busy1)
  );

  // ---------------- counters and check helper ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // ---------------- meas_in generator ----------------
  int   meas_mode = 2;  // 0 periodic, 1 random, 2 constant
  int   meas_period = 10;
  int   ph = 0;
  logic meas_const = 1'b0;

  initial forever begin
    @(posedge clk);
    #2;
    case (meas_mode)
      0: begin
        ph = (ph + 1) % meas_period;
        meas_in = (ph < meas_period / 2);
      end
      1: meas_in = 1'($urandom_range(0, 1));
      default: meas_in = meas_const;
    endcase
  end

  // ---------------- history of meas_in as seen at each clock edge ----------------
  int cyc = 0;
  bit m_hist [MAXC];

  always @(posedge clk) begin
    if (cyc + 1 < MAXC) m_hist[cyc + 1] <= reset_n ? meas_in : 1'b0;
    cyc <= cyc + 1;
  end

  // Number of 0->1 transitions of meas_in that fall in the G-edge window ending at
  // edge c, delayed by the synchroniser depth.
  function automatic longint model_cnt(input int c);
    longint n;
    n = 0;
    for (int j = c - G + 1; j <= c; j++)
      if (m_hist[j - S] && !m_hist[j - S - 1]) n++;
    return n;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;
  int           next_pub = -1;
  bit           oneshot_run = 0;
  bit           chk_en = 0;
  bit           pending;
  longint       n_model;
  logic [31:0]  exp_f0 = '0, exp_f1 = '0;
  logic         exp_o0 = 1'b0, exp_o1 = 1'b0, exp_valid = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      pending = (cyc == next_pub);
      if (pending) begin
        n_model = model_cnt(cyc);
        exp_q.push_back({n_model > MAX0, 32'(n_model > MAX0 ? MAX0 : n_model),
                         n_model > MAX1, 32'(n_model > MAX1 ? MAX1 : n_model)});
        next_pub = oneshot_run ? -1 : next_pub + G;
      end
      check("update0", 64'(upd0), 64'(pending));
      check("update1", 64'(upd1), 64'(pending));
      if (upd0) begin
        if (exp_q.size() == 0) begin
          check("spurious_publish", 64'(upd0), 64'd0);
        end else begin
          exp_w     = exp_q.pop_front();
          exp_o0    = exp_w[65];
          exp_f0    = exp_w[64:33];
          exp_o1    = exp_w[32];
          exp_f1    = exp_w[31:0];
          exp_valid = 1'b1;
        end
      end
      check("freq0", 64'(freq0), 64'(exp_f0));
      check("freq1", 64'(freq1), 64'(exp_f1));
      check("ovf0", 64'(ovf0), 64'(exp_o0));
      check("ovf1", 64'(ovf1), 64'(exp_o1));
      check("valid0", 64'(val0), 64'(exp_valid));
      check("valid1", 64'(val1), 64'(exp_valid));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic start_cont();
    oneshot     = 1'b0;
    enable      = 1'b1;
    oneshot_run = 0;
    next_pub    = cyc + 1 + G;
  endtask

  task automatic start_one();
    oneshot     = 1'b1;
    enable      = 1'b1;
    start       = 1'b1;
    oneshot_run = 1;
    next_pub    = cyc + 1 + G;
    tick(1);
    start = 1'b0;
  endtask

  task automatic stop();
    enable = 1'b0;
    if (next_pub == cyc) oneshot_run = 1;  // publish already visible this cycle, no more
    else next_pub = -1;
  endtask

  task automatic apply_reset(input int hold);
    chk_en  = 0;
    stop();
    reset_n = 1'b0;
    tick(1);
    check("rst_freq0", 64'(freq0), 64'd0);
    check("rst_freq1", 64'(freq1), 64'd0);
    check("rst_update", 64'({upd0, upd1}), 64'd0);
    check("rst_valid", 64'({val0, val1}), 64'd0);
    check("rst_overflow", 64'({ovf0, ovf1}), 64'd0);
    check("rst_busy", 64'({busy0, busy1}), 64'd0);
    tick(hold);
    exp_q.delete();
    next_pub  = -1;
    exp_f0    = '0;
    exp_f1    = '0;
    exp_o0    = 1'b0;
    exp_o1    = 1'b0;
    exp_valid = 1'b0;
    reset_n   = 1'b1;
    chk_en    = 1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          one;
    int          period;
    int          wins;
    logic [31:0] f0;
    logic        o0;
    logic [31:0] f1;
    logic        o1;
  } vec_t;

  vec_t vecs [4];
  int   t;

  initial begin
    vecs[0] = '{one: 0, period: 10, wins: 3, f0: 32'd10, o0: 1'b0, f1: 32'd10, o1: 1'b0};
    vecs[1] = '{one: 1, period: 4,  wins: 1, f0: 32'd25, o0: 1'b0, f1: 32'd15, o1: 1'b1};
    vecs[2] = '{one: 0, period: 2,  wins: 2, f0: 32'd50, o0: 1'b0, f1: 32'd15, o1: 1'b1};
    vecs[3] = '{one: 0, period: 20, wins: 2, f0: 32'd5,  o0: 1'b0, f1: 32'd5,  o1: 1'b0};

    tick(1);
    apply_reset(S + 3);
    tick(S + 1);
    check("idle_busy", 64'(busy0), 64'd0);

    for (int i = 0; i < 4; i++) begin
      meas_mode   = 0;
      meas_period = vecs[i].period;
      ph          = 0;
      tick(S + 4);
      if (vecs[i].one) begin
        start_one();
        check("busy_measure", 64'(busy0), 64'd1);
        tick(40);
        start = 1'b1;  // ignored while measuring
        tick(1);
        start = 1'b0;
      end else begin
        start_cont();
      end
      t = next_pub;
      wait_until(t + (vecs[i].wins - 1) * G);
      check("tbl_update", 64'(upd0), 64'd1);
      check("tbl_freq0", 64'(freq0), 64'(vecs[i].f0));
      check("tbl_ovf0", 64'(ovf0), 64'(vecs[i].o0));
      check("tbl_freq1", 64'(freq1), 64'(vecs[i].f1));
      check("tbl_ovf1", 64'(ovf1), 64'(vecs[i].o1));
      if (vecs[i].one) begin
        check("oneshot_busy_fall", 64'(busy0), 64'd0);
        tick(2 * G);
        check("oneshot_no_more", 64'(freq0), 64'(vecs[i].f0));
      end
      stop();
      tick(2);
    end

    // Abort mid-window: no publish, value held, restart gives a full window.
    meas_mode = 0;
    meas_period = 10;
    ph = 0;
    tick(S + 4);
    start_cont();
    t = next_pub;
    wait_until(t + 50);
    stop();
    tick(30);
    check("abort_hold_freq", 64'(freq0), 64'd10);
    check("abort_busy", 64'(busy0), 64'd0);
    start_cont();
    t = next_pub;
    wait_until(t - 1);
    check("restart_no_early", 64'(upd0), 64'd0);
    wait_until(t);
    check("restart_update", 64'(upd0), 64'd1);
    check("restart_freq", 64'(freq0), 64'd10);
    stop();
    tick(2);

    // Single rise landing on the terminal cycle of a window.
    meas_mode  = 2;
    meas_const = 1'b0;
    tick(S + 4);
    start_cont();
    t = next_pub;
    wait_until(t - S - 1);
    meas_const = 1'b1;
    wait_until(t);
    check("term_rise_freq", 64'(freq0), 64'd1);
    wait_until(t + G);
    check("term_next_update", 64'(upd0), 64'd1);
    check("term_next_freq", 64'(freq0), 64'd0);
    stop();
    tick(2);

    // Randomised windows with random abort points, including the terminal cycle.
    for (int r = 0; r < 8; r++) begin
      int nw;
      int off;
      meas_mode = 1;
      tick(S + 2);
      start_cont();
      nw  = $urandom_range(1, 3);
      off = (r == 0) ? G - 1 : $urandom_range(0, G - 1);
      t   = next_pub;
      wait_until(t + (nw - 1) * G + off);
      stop();
      tick($urandom_range(S + 1, 12));
    end

    // Reset in the middle of a window with meas_in held high across release.
    meas_mode = 0;
    meas_period = 10;
    ph = 0;
    tick(S + 4);
    start_cont();
    wait_until(next_pub + 40);
    meas_mode  = 2;
    meas_const = 1'b1;
    apply_reset(S + 3);
    tick(S + 1);
    start_cont();
    t = next_pub;
    wait_until(t);
    check("post_reset_update", 64'(upd0), 64'd1);
    check("post_reset_freq", 64'(freq0), 64'd0);
    check("post_reset_valid", 64'(val0), 64'd1);
    stop();
    tick(4);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    n_chk++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule
